// File: rtl/wb_stage.sv
// Writeback stage: owns the architectural register file, formats and commits results,
// issues the registered fetch redirect for taken control flow, and keeps cycle/instret counters.
module wb_stage #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            WB_V,
    input  logic [18:0]     WB_Cst,
    input  logic [XLEN-1:0] WB_RES,
    input  logic            WB_PC_MUX,
    input  logic [XLEN-1:0] WB_NPC,
    input  logic [31:0]     WB_IR,
    input  logic [XLEN-1:0] WB_Target_Address,
    input  logic [4:0]      DE_SR1,
    input  logic [4:0]      DE_SR2,
    output logic [XLEN-1:0] DE_SR1_Data,
    output logic [XLEN-1:0] DE_SR2_Data,
    output logic [4:0]      WB_DR,
    output logic            WB_FE_BR_STALL,
    output logic            FE_PC_LD,
    output logic [XLEN-1:0] FE_PC_Target,
    output logic [XLEN-1:0] CYCLE_CNT,
    output logic [XLEN-1:0] INSTRET_CNT
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_D  = 3'b011,
        LD_BU = 3'b100,
        LD_HU = 3'b101,
        LD_WU = 3'b110,
        LD_RAW = 3'b111
    } load_fmt_e;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    load_fmt_e       funct3;
    logic            is_load;
    logic            is_jal;
    logic            is_jalr;
    logic            is_branch;
    logic            is_cf;
    logic            wr_en;
    logic            redirect;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] commit_data;
    logic [XLEN-1:0] redirect_target;

    // Only the write-enable bit of the control word and the low IR fields matter here.
    logic unused_ok;
    assign unused_ok = ^{WB_Cst[18:7], WB_Cst[5:0], WB_IR[31:15]};

    assign opcode    = WB_IR[6:0];
    assign funct3    = load_fmt_e'(WB_IR[14:12]);
    assign WB_DR     = WB_IR[11:7];

    assign is_load   = (opcode == OP_LOAD);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_cf     = is_jal | is_jalr | is_branch;

    assign WB_FE_BR_STALL = WB_V & is_cf;

    // Reset gates the write so a pending instruction neither lands nor bypasses during reset.
    assign wr_en    = RESET_N & WB_V & WB_Cst[6] & (WB_DR != 5'd0);
    assign redirect = WB_V & is_cf & WB_PC_MUX;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        load_data = WB_RES;
        unique case (funct3)
            LD_B:    load_data = XLEN'($signed(WB_RES[7:0]));
            LD_H:    load_data = XLEN'($signed(WB_RES[15:0]));
            LD_W:    load_data = XLEN'($signed(WB_RES[31:0]));
            LD_D:    load_data = WB_RES;
            LD_BU:   load_data = XLEN'(WB_RES[7:0]);
            LD_HU:   load_data = XLEN'(WB_RES[15:0]);
            LD_WU:   load_data = XLEN'(WB_RES[31:0]);
            LD_RAW:  load_data = WB_RES;
            default: load_data = WB_RES;
        endcase
    end

    always_comb begin
        commit_data = WB_RES;
        if (is_jal || is_jalr) begin
            commit_data = WB_NPC;
        end else if (is_load) begin
            commit_data = load_data;
        end
    end

    // JALR targets are halfword-aligned by clearing bit 0; other targets pass through.
    always_comb begin
        redirect_target = WB_Target_Address;
        if (is_jalr) begin
            redirect_target = {WB_Target_Address[XLEN-1:1], 1'b0};
        end
    end

    // Read ports: x0 is zero, a same-cycle write is bypassed, otherwise the array.
    assign DE_SR1_Data = (DE_SR1 == 5'd0)              ? '0          :
                         (wr_en && (DE_SR1 == WB_DR))  ? commit_data :
                                                         regs[DE_SR1];

    assign DE_SR2_Data = (DE_SR2 == 5'd0)              ? '0          :
                         (wr_en && (DE_SR2 == WB_DR))  ? commit_data :
                                                         regs[DE_SR2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            // NOTE: the register file is architecturally cleared on reset, so the array is reset too.
            regs         <= '{default: '0};
            FE_PC_LD     <= 1'b0;
            FE_PC_Target <= '0;
            CYCLE_CNT    <= '0;
            INSTRET_CNT  <= '0;
        end else begin
            if (wr_en) begin
                regs[WB_DR] <= commit_data;
            end

            FE_PC_LD <= redirect;
            if (redirect) begin
                FE_PC_Target <= redirect_target;
            end

            CYCLE_CNT <= CYCLE_CNT + 1'b1;
            if (WB_V) begin
                INSTRET_CNT <= INSTRET_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for commit formatting and redirects,
// plus hand-written sequences for reset, back-to-back branches and counter wrap.
module tb_wb_stage;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic        CLK;
    logic        RESET_N;
    logic        WB_V;
    logic [18:0] WB_Cst;
    logic [63:0] WB_RES;
    logic        WB_PC_MUX;
    logic [63:0] WB_NPC;
    logic [31:0] WB_IR;
    logic [63:0] WB_Target_Address;
    logic [4:0]  DE_SR1;
    logic [4:0]  DE_SR2;
    logic [63:0] DE_SR1_Data;
    logic [63:0] DE_SR2_Data;
    logic [4:0]  WB_DR;
    logic        WB_FE_BR_STALL;
    logic        FE_PC_LD;
    logic [63:0] FE_PC_Target;
    logic [63:0] CYCLE_CNT;
    logic [63:0] INSTRET_CNT;

    wb_stage dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .WB_V              (WB_V),
        .WB_Cst            (WB_Cst),
        .WB_RES            (WB_RES),
        .WB_PC_MUX         (WB_PC_MUX),
        .WB_NPC            (WB_NPC),
        .WB_IR             (WB_IR),
        .WB_Target_Address (WB_Target_Address),
        .DE_SR1            (DE_SR1),
        .DE_SR2            (DE_SR2),
        .DE_SR1_Data       (DE_SR1_Data),
        .DE_SR2_Data       (DE_SR2_Data),
        .WB_DR             (WB_DR),
        .WB_FE_BR_STALL    (WB_FE_BR_STALL),
        .FE_PC_LD          (FE_PC_LD),
        .FE_PC_Target      (FE_PC_Target),
        .CYCLE_CNT         (CYCLE_CNT),
        .INSTRET_CNT       (INSTRET_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Presents one instruction in WB and points both read ports at its destination.
    task automatic drive(input logic v, input logic we, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] res, input logic pcmux,
                         input logic [63:0] npc, input logic [63:0] tgt);
        WB_V              = v;
        WB_Cst            = '0;
        WB_Cst[6]         = we;
        WB_IR             = {17'h0, f3, rd, op};
        WB_RES            = res;
        WB_PC_MUX         = pcmux;
        WB_NPC            = npc;
        WB_Target_Address = tgt;
        DE_SR1            = rd;
        DE_SR2            = rd;
    endtask

    task automatic idle(input logic [4:0] rd);
        drive(1'b0, 1'b0, OP_IMM, 3'b000, 5'd0, 64'h0, 1'b0, 64'h0, 64'h0);
        DE_SR1 = rd;
        DE_SR2 = rd;
    endtask

    typedef struct {
        string       name;
        logic        v;
        logic        we;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        pcmux;
        logic [63:0] npc;
        logic [63:0] tgt;
        logic [63:0] exp_byp;
        logic [63:0] exp_arr;
        logic        exp_stall;
        logic        exp_ld;
        logic [63:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];
    int   exp_instret;

    initial begin
        // ---- Reset held two cycles with a write pending ----
        RESET_N = 1'b0;
        drive(1'b1, 1'b1, OP_IMM, 3'b000, 5'd5, 64'hAA, 1'b0, 64'h0, 64'h0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("reset_bypass_gated", DE_SR1_Data, 64'h0);
        check("reset_fe_pc_ld", {63'h0, FE_PC_LD}, 64'h0);
        check("reset_cycle", CYCLE_CNT, 64'h0);
        check("reset_instret", INSTRET_CNT, 64'h0);
        RESET_N = 1'b1;
        idle(5'd5);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("cycle_after_release", CYCLE_CNT, 64'h1);
        check("x5_after_reset", DE_SR1_Data, 64'h0);

        // ---- Vector table: one instruction cycle then one idle cycle each ----
        //          name           v   we  op         f3      rd     res                      pm  npc        tgt        byp                      arr                      st  ld  exp_tgt
        vecs.push_back('{"addi_x5",  1, 1, OP_IMM,    3'b000, 5'd5,  64'h1234,                0, 64'h0,     64'h0,     64'h1234,                64'h1234,                0, 0, 64'h0});
        vecs.push_back('{"addi_x0",  1, 1, OP_IMM,    3'b000, 5'd0,  64'hFF,                  0, 64'h0,     64'h0,     64'h0,                   64'h0,                   0, 0, 64'h0});
        vecs.push_back('{"lb",       1, 1, OP_LOAD,   3'b000, 5'd6,  64'h80,                  0, 64'h0,     64'h0,     64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 64'h0});
        vecs.push_back('{"lbu",      1, 1, OP_LOAD,   3'b100, 5'd7,  64'h80,                  0, 64'h0,     64'h0,     64'h80,                  64'h80,                  0, 0, 64'h0});
        vecs.push_back('{"lw",       1, 1, OP_LOAD,   3'b010, 5'd8,  64'h8000_0000,           0, 64'h0,     64'h0,     64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 0, 0, 64'h0});
        vecs.push_back('{"lh",       1, 1, OP_LOAD,   3'b001, 5'd9,  64'h1234_8001,           0, 64'h0,     64'h0,     64'hFFFF_FFFF_FFFF_8001, 64'hFFFF_FFFF_FFFF_8001, 0, 0, 64'h0});
        vecs.push_back('{"lhu",      1, 1, OP_LOAD,   3'b101, 5'd10, 64'hFFFF_8001,           0, 64'h0,     64'h0,     64'h8001,                64'h8001,                0, 0, 64'h0});
        vecs.push_back('{"lwu",      1, 1, OP_LOAD,   3'b110, 5'd11, 64'hFFFF_FFFF_8000_0000, 0, 64'h0,     64'h0,     64'h8000_0000,           64'h8000_0000,           0, 0, 64'h0});
        vecs.push_back('{"ld",       1, 1, OP_LOAD,   3'b011, 5'd12, 64'hDEAD_BEEF_0123_4567, 0, 64'h0,     64'h0,     64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 0, 0, 64'h0});
        vecs.push_back('{"load_raw", 1, 1, OP_LOAD,   3'b111, 5'd13, 64'h0123_4567_89AB_CDEF, 0, 64'h0,     64'h0,     64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h0});
        vecs.push_back('{"no_we",    1, 0, OP_IMM,    3'b000, 5'd14, 64'h55,                  0, 64'h0,     64'h0,     64'h0,                   64'h0,                   0, 0, 64'h0});
        vecs.push_back('{"invalid",  0, 1, OP_IMM,    3'b000, 5'd15, 64'h66,                  0, 64'h0,     64'h0,     64'h0,                   64'h0,                   0, 0, 64'h0});
        vecs.push_back('{"jalr",     1, 1, OP_JALR,   3'b000, 5'd1,  64'h9999,                1, 64'h104,   64'h201,   64'h104,                 64'h104,                 1, 1, 64'h200});
        vecs.push_back('{"jal",      1, 1, OP_JAL,    3'b000, 5'd2,  64'h9999,                1, 64'h2000,  64'h3001,  64'h2000,                64'h2000,                1, 1, 64'h3001});
        vecs.push_back('{"addi_x16", 1, 1, OP_IMM,    3'b000, 5'd16, 64'h77,                  0, 64'h0,     64'h0,     64'h77,                  64'h77,                  0, 0, 64'h3001});
        vecs.push_back('{"jal_nt",   1, 1, OP_JAL,    3'b000, 5'd17, 64'h0,                   0, 64'h3004,  64'h5000,  64'h3004,                64'h3004,                1, 0, 64'h3001});

        exp_instret = 0;
        foreach (vecs[i]) begin
            if (vecs[i].v) exp_instret++;
            drive(vecs[i].v, vecs[i].we, vecs[i].op, vecs[i].f3, vecs[i].rd, vecs[i].res,
                  vecs[i].pcmux, vecs[i].npc, vecs[i].tgt);
            #1;
            check({vecs[i].name, "_bypass"}, DE_SR1_Data, vecs[i].exp_byp);
            check({vecs[i].name, "_stall"}, {63'h0, WB_FE_BR_STALL}, {63'h0, vecs[i].exp_stall});
            @(posedge CLK);
            @(negedge CLK);
            idle(vecs[i].rd);
            #1;
            check({vecs[i].name, "_array"}, DE_SR2_Data, vecs[i].exp_arr);
            check({vecs[i].name, "_fe_pc_ld"}, {63'h0, FE_PC_LD}, {63'h0, vecs[i].exp_ld});
            check({vecs[i].name, "_fe_pc_target"}, FE_PC_Target, vecs[i].exp_tgt);
            @(posedge CLK);
            @(negedge CLK);
            #1;
            check({vecs[i].name, "_pulse_cleared"}, {63'h0, FE_PC_LD}, 64'h0);
        end
        check("instret_after_table", INSTRET_CNT, 64'(exp_instret));

        // ---- Not-taken BEQ then taken BNE, back to back; rd field nonzero but no write enable ----
        drive(1'b1, 1'b0, OP_BRANCH, 3'b000, 5'd5, 64'hBAD, 1'b0, 64'h0, 64'h700);
        #1;
        check("beq_stall", {63'h0, WB_FE_BR_STALL}, 64'h1);
        @(posedge CLK);
        @(negedge CLK);
        drive(1'b1, 1'b0, OP_BRANCH, 3'b001, 5'd1, 64'hBAD, 1'b1, 64'h0, 64'h400);
        #1;
        check("beq_no_pulse", {63'h0, FE_PC_LD}, 64'h0);
        @(posedge CLK);
        @(negedge CLK);
        idle(5'd5);
        DE_SR2 = 5'd1;
        #1;
        check("bne_pulse", {63'h0, FE_PC_LD}, 64'h1);
        check("bne_target", FE_PC_Target, 64'h400);
        check("branch_instret", INSTRET_CNT, 64'(exp_instret + 2));
        check("branch_x5_kept", DE_SR1_Data, 64'h1234);
        check("branch_x1_kept", DE_SR2_Data, 64'h104);

        // ---- Two taken branches on consecutive cycles, each with its own target ----
        drive(1'b1, 1'b0, OP_BRANCH, 3'b001, 5'd0, 64'h0, 1'b1, 64'h0, 64'h500);
        @(posedge CLK);
        @(negedge CLK);
        drive(1'b1, 1'b0, OP_BRANCH, 3'b001, 5'd0, 64'h0, 1'b1, 64'h0, 64'h600);
        #1;
        check("b2b_first_pulse", {63'h0, FE_PC_LD}, 64'h1);
        check("b2b_first_target", FE_PC_Target, 64'h500);
        @(posedge CLK);
        @(negedge CLK);
        idle(5'd0);
        #1;
        check("b2b_second_pulse", {63'h0, FE_PC_LD}, 64'h1);
        check("b2b_second_target", FE_PC_Target, 64'h600);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("b2b_pulse_end", {63'h0, FE_PC_LD}, 64'h0);

        // ---- INSTRET wrap from all-ones ----
        force dut.INSTRET_CNT = '1;
        @(posedge CLK);
        @(negedge CLK);
        release dut.INSTRET_CNT;
        #1;
        check("instret_preload", INSTRET_CNT, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, 1'b0, OP_IMM, 3'b000, 5'd0, 64'h0, 1'b0, 64'h0, 64'h0);
        @(posedge CLK);
        @(negedge CLK);
        idle(5'd3);
        #1;
        check("instret_wrap", INSTRET_CNT, 64'h0);

        // ---- Reset lands while a taken JAL is in WB ----
        drive(1'b1, 1'b1, OP_JAL, 3'b000, 5'd3, 64'h0, 1'b1, 64'h804, 64'h900);
        RESET_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        idle(5'd3);
        #1;
        check("reset_jal_no_pulse", {63'h0, FE_PC_LD}, 64'h0);
        check("reset_jal_target", FE_PC_Target, 64'h0);
        check("reset_jal_rd", DE_SR1_Data, 64'h0);
        check("reset_jal_cycle", CYCLE_CNT, 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage. Consumes the registered WB_* bundle produced by the memory stage.
- Holds the 32x64 architectural register file and exposes two read ports to decode.
- Formats and commits the result, issues the registered fetch redirect for taken control flow, and keeps the cycle and retired-instruction counters.

Parameters:
XLEN, 64, datapath and register width
NREGS, 32, architectural register count; x0 hardwired to zero

Ports:
CLK  in  1  clock, all state updates on posedge
RESET_N  in  1  reset; one clock; reset is synchronous and active-low
WB_V  in  1  valid for the WB bundle
WB_Cst  in  19  control store word; bit6 = register write enable
WB_RES  in  64  ALU result or raw load data
WB_PC_MUX  in  1  1 = control flow taken
WB_NPC  in  64  PC+4 of the instruction
WB_IR  in  32  instruction word
WB_Target_Address  in  64  branch/jump target
DE_SR1  in  5  decode read address 1
DE_SR2  in  5  decode read address 2
DE_SR1_Data  out  64  read data 1 (combinational, with bypass)
DE_SR2_Data  out  64  read data 2 (combinational, with bypass)
WB_DR  out  5  WB_IR[11:7] (combinational)
WB_FE_BR_STALL  out  1  fetch hold while control flow sits in WB (combinational)
FE_PC_LD  out  1  registered one-cycle redirect pulse
FE_PC_Target  out  64  registered redirect target
CYCLE_CNT  out  64  cycles since reset
INSTRET_CNT  out  64  retired valid instructions

Behaviour:
- Reset: when RESET_N=0 at a posedge, all 32 registers, FE_PC_LD, FE_PC_Target, CYCLE_CNT and INSTRET_CNT clear to 0. Any pending redirect is dropped. Inputs are ignored that cycle.
- Opcode classes from WB_IR[6:0]:
  - LOAD = 0000011
  - JAL = 1101111
  - JALR = 1100111
  - BRANCH = 1100011
  - CF = JAL | JALR | BRANCH
- Commit data:
  - JAL/JALR: commit WB_NPC.
  - LOAD: extend WB_RES per funct3 = WB_IR[14:12]:
    - 000 sign-extend [7:0]; 001 sign-extend [15:0]; 010 sign-extend [31:0]; 011 full 64 bits
    - 100 zero-extend [7:0]; 101 zero-extend [15:0]; 110 zero-extend [31:0]
    - 111: commit WB_RES unchanged
  - Otherwise: commit WB_RES.
- Register write: at posedge when WB_V & WB_Cst[6] & (WB_DR != 0). Writes to x0 are discarded, and x0 always reads 0.
- Read ports, combinational:
  - Address 0 returns 0.
  - If the address equals WB_DR and a write is occurring this cycle, return the commit data (same-cycle bypass).
  - Otherwise return the array contents.
- Redirect:
  - WB_FE_BR_STALL = WB_V & CF.
  - At the posedge where WB_V & CF & WB_PC_MUX: FE_PC_LD <= 1 and FE_PC_Target <= WB_Target_Address, with bit0 forced to 0 for JALR.
  - In every other cycle FE_PC_LD <= 0, and FE_PC_Target holds its value.
  - A not-taken branch produces no pulse.
  - Back-to-back taken CF instructions produce a pulse on each consecutive cycle, each carrying its own target.
- Counters:
  - CYCLE_CNT increments every non-reset cycle.
  - INSTRET_CNT increments when WB_V=1, whether or not the instruction writes a register.
  - Both wrap modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF -> 0), with no flag.
- WB_V=0: no register write, no redirect, no INSTRET increment. The other WB_* inputs are don't-care.
- Latency: register write is visible on the read ports in the same cycle via bypass, and from the array from the next cycle. The redirect appears 1 cycle after the instruction is in WB.

Test Plan:
- Reset: hold RESET_N=0 for 2 cycles with WB_V=1 and writes pending -> all reads return 0, FE_PC_LD=0, both counters 0. Release -> CYCLE_CNT=1 after the first posedge.
- ADDI x5 with WB_Cst[6]=1, WB_RES=0x1234, DE_SR1=5 in the same cycle -> DE_SR1_Data=0x1234 (bypass), then 0x1234 from the array next cycle. Write to x0 with 0xFF -> reads 0.
- LB with WB_RES=0x80 -> x6 = 0xFFFF_FFFF_FFFF_FF80. LBU with WB_RES=0x80 -> 0x80. LW with WB_RES=0x0000_0000_8000_0000 -> 0xFFFF_FFFF_8000_0000.
- JALR: WB_V=1, WB_PC_MUX=1, WB_NPC=0x104, target=0x201 -> rd=0x104, WB_FE_BR_STALL=1 that cycle, FE_PC_LD=1 with FE_PC_Target=0x200 for exactly one cycle.
- Not-taken BEQ followed by taken BNE with target 0x400 -> no pulse for BEQ, pulse with 0x400 for BNE. INSTRET advances by 2 and no registers change.
- Preload INSTRET_CNT to all-ones by forcing, retire 1 instruction -> 0. Reset asserted in the cycle a taken JAL is in WB -> FE_PC_LD stays 0 and rd is unchanged.
